// File: rtl/feature_row_splitter_pkg.sv
// Shared constants for the feature-row splitter: FSM encoding, default widths
// (kept in step with the convolution engine configuration) and ratio helpers.
package feature_row_splitter_pkg;

  localparam int IN_WIDTH_DEF  = 256;
  localparam int OUT_WIDTH_DEF = 64;
  localparam int COL_WIDTH_DEF = 12;
  localparam int ROW_WIDTH_DEF = 12;
  localparam int CHW_WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int ratio_of(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // A single-lane configuration still needs a 1-bit lane counter to stay legal.
  function automatic int lane_bits(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/feature_row_splitter_frame_counter_chain.sv
// Channel-word / column / row cascade. Counters describe the word currently
// held (or the next one to load when the hold register is empty).
module frame_counter_chain
  import feature_row_splitter_pkg::*;
#(
  parameter int COL_WIDTH = COL_WIDTH_DEF,
  parameter int ROW_WIDTH = ROW_WIDTH_DEF,
  parameter int CHW_WIDTH = CHW_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [CHW_WIDTH-1:0] chw_num,
  input  logic [COL_WIDTH-1:0] col_num,
  input  logic [ROW_WIDTH-1:0] row_num,
  output logic                 last_pixel,
  output logic                 last_row,
  output logic                 last_frame
);

  localparam logic [CHW_WIDTH-1:0] CHW_ONE = CHW_WIDTH'(1);
  localparam logic [COL_WIDTH-1:0] COL_ONE = COL_WIDTH'(1);
  localparam logic [ROW_WIDTH-1:0] ROW_ONE = ROW_WIDTH'(1);

  logic [CHW_WIDTH-1:0] chw_reg;
  logic [COL_WIDTH-1:0] col_reg;
  logic [ROW_WIDTH-1:0] row_reg;
  logic                 col_last;

  assign col_last   = (col_reg == col_num - COL_ONE);
  assign last_pixel = (chw_reg == chw_num - CHW_ONE);
  assign last_row   = last_pixel && col_last;
  assign last_frame = last_row && (row_reg == row_num - ROW_ONE);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      chw_reg <= '0;
      col_reg <= '0;
      row_reg <= '0;
    end else if (advance) begin
      if (last_pixel) begin
        chw_reg <= '0;
        if (col_last) begin
          col_reg <= '0;
          row_reg <= last_frame ? '0 : row_reg + ROW_ONE;
        end else begin
          col_reg <= col_reg + COL_ONE;
        end
      end else begin
        chw_reg <= chw_reg + CHW_ONE;
      end
    end
  end

endmodule

// File: rtl/feature_row_splitter.sv
// Splits 256-bit feature-map words into narrower beats (LSB lane first) and
// tags each beat with pixel/row/frame boundary flags for one armed frame.
module feature_row_splitter
  import feature_row_splitter_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int COL_WIDTH = COL_WIDTH_DEF,
  parameter int ROW_WIDTH = ROW_WIDTH_DEF,
  parameter int CHW_WIDTH = CHW_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start,
  input  logic [COL_WIDTH-1:0] Col_Num,
  input  logic [ROW_WIDTH-1:0] Row_Num,
  input  logic [CHW_WIDTH-1:0] Ch_Words,
  input  logic [IN_WIDTH-1:0]  S_Data,
  input  logic                 S_Valid,
  output logic                 S_Ready,
  output logic [OUT_WIDTH-1:0] M_Data,
  output logic                 M_Valid,
  input  logic                 M_Ready,
  output logic                 M_Last_Pixel,
  output logic                 M_Last_Row,
  output logic                 M_Last_Frame,
  output logic                 Busy,
  output logic                 Done
);

  localparam int RATIO  = ratio_of(IN_WIDTH, OUT_WIDTH);
  localparam int LANE_W = lane_bits(RATIO);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);

  logic [1:0]           state_reg, state_next;
  logic [IN_WIDTH-1:0]  hold_reg;
  logic                 hold_valid_reg;
  logic [LANE_W-1:0]    lane_reg;
  logic [COL_WIDTH-1:0] col_num_reg;
  logic [ROW_WIDTH-1:0] row_num_reg;
  logic [CHW_WIDTH-1:0] chw_num_reg;
  logic                 start_ok, lane_last, m_fire, s_fire, advance;
  logic                 last_pixel_word, last_row_word, last_frame_word;
  logic [OUT_WIDTH-1:0] lane_data [RATIO];

  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      assign lane_data[gi] = hold_reg[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  assign start_ok  = (state_reg == ST_IDLE) && Start &&
                     (|Col_Num) && (|Row_Num) && (|Ch_Words);
  assign lane_last = (lane_reg == LANE_LAST);
  assign m_fire    = hold_valid_reg && M_Ready;
  assign advance   = m_fire && lane_last;
  // Once the final word is held, no further upstream words are pulled.
  assign S_Ready   = (state_reg == ST_RUN) && !(hold_valid_reg && last_frame_word) &&
                     (!hold_valid_reg || (lane_last && M_Ready));
  assign s_fire    = S_Valid && S_Ready;

  assign M_Valid      = hold_valid_reg;
  assign M_Data       = hold_valid_reg ? lane_data[lane_reg] : '0;
  assign M_Last_Pixel = hold_valid_reg && lane_last && last_pixel_word;
  assign M_Last_Row   = hold_valid_reg && lane_last && last_row_word;
  assign M_Last_Frame = hold_valid_reg && lane_last && last_frame_word;
  assign Busy         = (state_reg == ST_RUN);
  assign Done         = (state_reg == ST_DONE);

  frame_counter_chain #(
    .COL_WIDTH (COL_WIDTH),
    .ROW_WIDTH (ROW_WIDTH),
    .CHW_WIDTH (CHW_WIDTH)
  ) u_counters (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .advance    (advance),
    .chw_num    (chw_num_reg),
    .col_num    (col_num_reg),
    .row_num    (row_num_reg),
    .last_pixel (last_pixel_word),
    .last_row   (last_row_word),
    .last_frame (last_frame_word)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_ok) state_next = ST_RUN;
      ST_RUN:  if (advance && last_frame_word) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      lane_reg       <= '0;
      col_num_reg    <= '0;
      row_num_reg    <= '0;
      chw_num_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        col_num_reg <= Col_Num;
        row_num_reg <= Row_Num;
        chw_num_reg <= Ch_Words;
      end
      // A load on the last-lane handshake takes priority over clearing the hold.
      if (s_fire) begin
        hold_reg       <= S_Data;
        hold_valid_reg <= 1'b1;
        lane_reg       <= '0;
      end else if (m_fire) begin
        if (lane_last) hold_valid_reg <= 1'b0;
        else           lane_reg       <= lane_reg + LANE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_feature_row_splitter.sv
// Self-checking bench: table of frame configurations driven with random data
// and checked beat by beat against a word/beat index model of the frame.
`timescale 1ns/1ps
module tb_feature_row_splitter;

  localparam int RATIO = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         Start = 1'b0;
  logic [11:0]  Col_Num = '0;
  logic [11:0]  Row_Num = '0;
  logic [7:0]   Ch_Words = '0;
  logic [255:0] S_Data = '0;
  logic         S_Valid = 1'b0;
  logic         S_Ready;
  logic [63:0]  M_Data;
  logic         M_Valid;
  logic         M_Ready = 1'b0;
  logic         M_Last_Pixel, M_Last_Row, M_Last_Frame, Busy, Done;

  always #5 clk = ~clk;

  feature_row_splitter dut (
    .clk          (clk),
    .rst          (rst),
    .Start        (Start),
    .Col_Num      (Col_Num),
    .Row_Num      (Row_Num),
    .Ch_Words     (Ch_Words),
    .S_Data       (S_Data),
    .S_Valid      (S_Valid),
    .S_Ready      (S_Ready),
    .M_Data       (M_Data),
    .M_Valid      (M_Valid),
    .M_Ready      (M_Ready),
    .M_Last_Pixel (M_Last_Pixel),
    .M_Last_Row   (M_Last_Row),
    .M_Last_Frame (M_Last_Frame),
    .Busy         (Busy),
    .Done         (Done)
  );

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  always @(negedge clk) if (Done === 1'b1) done_cnt++;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    int col; int row; int chw;
    int rmode;       // 0: always ready, 1: pattern 1,0,0,1, 2: random
    int vmode;       // 0: S_Valid held high, 1: random
    int exp_words; int exp_beats; int exp_pix; int exp_rows;
    int exp_cycles;  // 0 = not checked
  } vec_t;

  vec_t tbl [6];

  task automatic run_frame(input vec_t v, input int stop_after);
    logic [255:0] words [$];
    logic [255:0] wtmp;
    logic [63:0]  prev_data, exp_data;
    logic [2:0]   prev_flags;
    bit           prev_stall, hold, exp_sready, timed_out;
    int total, loaded, beats, lane, w, n_pix, n_rows, n_frames, n_cycles, phase, target;
    total = v.col * v.row * v.chw;
    target = (stop_after > 0) ? stop_after : total * RATIO;
    loaded = 0; beats = 0; n_pix = 0; n_rows = 0; n_frames = 0; n_cycles = 0;
    phase = 0; prev_stall = 0; timed_out = 0; prev_data = '0; prev_flags = '0;
    for (int i = 0; i < total; i++)
      words.push_back({$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom});

    @(negedge clk);
    Col_Num = 12'(v.col); Row_Num = 12'(v.row); Ch_Words = 8'(v.chw);
    Start = 1'b1; S_Valid = 1'b0; M_Ready = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    Col_Num = 12'($urandom); Row_Num = 12'($urandom); Ch_Words = 8'($urandom);

    while (beats < target) begin
      if (n_cycles > 4000) begin
        timed_out = 1;
        break;
      end
      case (v.rmode)
        0:       M_Ready = 1'b1;
        1:       M_Ready = (phase % 4 == 0) || (phase % 4 == 3);
        default: M_Ready = 1'($urandom_range(0, 1));
      endcase
      phase++;
      S_Valid = (v.vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      S_Data  = (loaded < total) ? words[loaded] : {8{$urandom}};
      #1;
      hold = (loaded * RATIO) > beats;
      lane = beats % RATIO;
      exp_sready = (loaded < total) && (!hold || (lane == RATIO - 1 && M_Ready));
      check_bit("busy", Busy, 1'b1);
      check_bit("m_valid", M_Valid, hold);
      check_bit("s_ready", S_Ready, exp_sready);
      if (prev_stall) begin
        check_val("stall_data", M_Data, prev_data);
        check_val("stall_flags", 64'({M_Last_Pixel, M_Last_Row, M_Last_Frame}), 64'(prev_flags));
      end
      if (hold && M_Ready) begin
        w = beats / RATIO;
        wtmp = words[w];
        exp_data = wtmp[lane*64 +: 64];
        check_val("m_data", M_Data, exp_data);
        check_bit("last_pixel", M_Last_Pixel, (lane == RATIO - 1) && ((w + 1) % v.chw == 0));
        check_bit("last_row", M_Last_Row, (lane == RATIO - 1) && ((w + 1) % (v.chw * v.col) == 0));
        check_bit("last_frame", M_Last_Frame, beats == total * RATIO - 1);
        n_pix += int'(M_Last_Pixel); n_rows += int'(M_Last_Row); n_frames += int'(M_Last_Frame);
        beats++;
      end else if (!hold) begin
        check_val("m_data_idle", M_Data, 64'h0);
      end
      prev_stall = M_Valid && !M_Ready;
      prev_data  = M_Data;
      prev_flags = {M_Last_Pixel, M_Last_Row, M_Last_Frame};
      if (S_Valid && S_Ready) loaded++;
      n_cycles++;
      @(negedge clk);
    end
    check_bit("frame_no_timeout", timed_out, 1'b0);
    if (stop_after == 0) begin
      #1;
      check_bit("done_pulse", Done, 1'b1);
      check_bit("busy_in_done", Busy, 1'b0);
      check_bit("m_valid_in_done", M_Valid, 1'b0);
      check_bit("s_ready_in_done", S_Ready, 1'b0);
      check_val("words_loaded", 64'(loaded), 64'(v.exp_words));
      check_val("beats", 64'(beats), 64'(v.exp_beats));
      check_val("pixel_flags", 64'(n_pix), 64'(v.exp_pix));
      check_val("row_flags", 64'(n_rows), 64'(v.exp_rows));
      check_val("frame_flags", 64'(n_frames), 64'h1);
      if (v.exp_cycles != 0) check_val("frame_cycles", 64'(n_cycles), 64'(v.exp_cycles));
      S_Valid = 1'b0;
      @(negedge clk);
      #1;
      check_bit("done_single_cycle", Done, 1'b0);
      check_bit("idle_busy", Busy, 1'b0);
    end
    S_Valid = 1'b0;
    M_Ready = 1'b0;
    $display("frame col=%0d row=%0d chw=%0d rmode=%0d: words=%0d beats=%0d cycles=%0d",
             v.col, v.row, v.chw, v.rmode, loaded, beats, n_cycles);
  endtask

  initial begin
    tbl[0] = '{col:2, row:1, chw:1, rmode:0, vmode:0, exp_words:2,  exp_beats:8,  exp_pix:2, exp_rows:1, exp_cycles:9};
    tbl[1] = '{col:4, row:1, chw:1, rmode:0, vmode:0, exp_words:4,  exp_beats:16, exp_pix:4, exp_rows:1, exp_cycles:17};
    tbl[2] = '{col:2, row:1, chw:1, rmode:1, vmode:0, exp_words:2,  exp_beats:8,  exp_pix:2, exp_rows:1, exp_cycles:0};
    tbl[3] = '{col:2, row:2, chw:3, rmode:0, vmode:0, exp_words:12, exp_beats:48, exp_pix:4, exp_rows:2, exp_cycles:49};
    tbl[4] = '{col:3, row:2, chw:2, rmode:2, vmode:1, exp_words:12, exp_beats:48, exp_pix:6, exp_rows:2, exp_cycles:0};
    tbl[5] = '{col:1, row:1, chw:1, rmode:2, vmode:1, exp_words:1,  exp_beats:4,  exp_pix:1, exp_rows:1, exp_cycles:0};

    // Reset state, with inputs pushing activity that must be ignored.
    Start = 1'b1; Col_Num = 12'd2; Row_Num = 12'd1; Ch_Words = 8'd1;
    S_Valid = 1'b1; M_Ready = 1'b1; S_Data = {8{32'hA5A5_5A5A}};
    repeat (3) @(negedge clk);
    #1;
    check_bit("rst_m_valid", M_Valid, 1'b0);
    check_bit("rst_s_ready", S_Ready, 1'b0);
    check_bit("rst_busy", Busy, 1'b0);
    check_bit("rst_done", Done, 1'b0);
    check_val("rst_flags", 64'({M_Last_Pixel, M_Last_Row, M_Last_Frame}), 64'h0);
    check_val("rst_m_data", M_Data, 64'h0);
    Start = 1'b0; S_Valid = 1'b0; M_Ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Start with any zero dimension must be ignored.
    for (int z = 0; z < 3; z++) begin
      @(negedge clk);
      Col_Num  = (z == 0) ? 12'd0 : 12'd2;
      Row_Num  = (z == 1) ? 12'd0 : 12'd1;
      Ch_Words = (z == 2) ? 8'd0  : 8'd1;
      Start = 1'b1; S_Valid = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      #1;
      check_bit("zero_cfg_busy", Busy, 1'b0);
      check_bit("zero_cfg_s_ready", S_Ready, 1'b0);
      @(negedge clk);
      #1;
      check_bit("zero_cfg_done", Done, 1'b0);
      check_bit("zero_cfg_m_valid", M_Valid, 1'b0);
      S_Valid = 1'b0;
    end

    for (int i = 0; i < 6; i++) run_frame(tbl[i], 0);

    // Reset in the middle of a frame, then a fresh frame from lane 0.
    run_frame(tbl[1], 5);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_bit("midrst_m_valid", M_Valid, 1'b0);
    check_bit("midrst_busy", Busy, 1'b0);
    check_bit("midrst_done", Done, 1'b0);
    check_val("midrst_m_data", M_Data, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_bit("midrst_no_done", Done, 1'b0);
    check_bit("midrst_idle", Busy, 1'b0);
    run_frame(tbl[0], 0);

    check_val("done_pulse_count", 64'(done_cnt), 64'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
